vsi_sram_bank_ctrl: RTL and testbench

//  Parametrised two-port (1 write, 1 read) storage bank; next generation of the fixed 128x128 bank.

---
 rtl/vsi_sram_bank_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_vsi_sram_bank_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vsi_sram_bank_ctrl.sv
// ----------------------------------------------------------------------------
// vsi_sram_bank_ctrl
//   Two-port (one write, one read) storage bank with byte-enable writes,
//   1- or 2-cycle read latency with a valid flag, and write-first bypass when
//   both ports hit the same word on the same edge. After reset, an optional
//   clear sequencer writes INIT_VALUE to every word before raising vsi_ready.
//
// Ports
//   vsi_clk               in   clock, all logic on the rising edge
//   vsi_reset             in   asynchronous active-high reset
//   vsi_inputData         in   write data
//   vsi_inputAddr         in   write address
//   vsi_inputChipSelect   in   write request
//   vsi_inputByteEn       in   byte enables, bit i -> data[8i+7:8i]
//   vsi_outputChipSelect  in   read request
//   vsi_outputAddr        in   read address
//   vsi_outputData        out  read data (holds the last result while not valid)
//   vsi_outputValid       out  one-cycle pulse per accepted read
//   vsi_ready             out  bank accepts requests
// ----------------------------------------------------------------------------
module vsi_sram_bank_ctrl #(
    parameter int                DATA_W         = 128,
    parameter int                DEPTH          = 128,
    parameter int                ADDR_W         = 7,
    parameter int                RD_LAT         = 1,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE     = '0
) (
    input  logic                  vsi_clk,
    input  logic                  vsi_reset,
    input  logic [DATA_W-1:0]     vsi_inputData,
    input  logic [ADDR_W-1:0]     vsi_inputAddr,
    input  logic                  vsi_inputChipSelect,
    input  logic [DATA_W/8-1:0]   vsi_inputByteEn,
    input  logic                  vsi_outputChipSelect,
    input  logic [ADDR_W-1:0]     vsi_outputAddr,
    output logic [DATA_W-1:0]     vsi_outputData,
    output logic                  vsi_outputValid,
    output logic                  vsi_ready
);

    localparam int                BYTES     = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   clr_cnt;
    logic                ready_q;

    logic                clear_we;
    logic                wr_in_range;
    logic                rd_in_range;
    logic                wr_fire;
    logic                rd_fire;
    logic [DATA_W-1:0]   rd_word;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;

    // ------------------------------------------------------------------
    // State register. ready is registered from the next state so it is
    // low throughout reset even when the bank starts directly in RUN.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values, regardless of block ordering.
    always_ff @(posedge vsi_clk or posedge vsi_reset) begin
        if (vsi_reset) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next == ST_RUN);
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Next-state logic: leave CLEAR on the edge that writes the last word.
    always_comb begin
        state_next = state;
        if (state == ST_CLEAR && clr_cnt == LAST_ADDR) begin
            state_next = ST_RUN;
        end
    end

    // Output / control decode. Requests count only once ready is up.
    always_comb begin
        clear_we    = (state == ST_CLEAR);
        wr_in_range = ({1'b0, vsi_inputAddr} < DEPTH_EXT);
        rd_in_range = ({1'b0, vsi_outputAddr} < DEPTH_EXT);
        wr_fire     = ready_q && vsi_inputChipSelect && wr_in_range;
        rd_fire     = ready_q && vsi_outputChipSelect;
    end

    assign vsi_ready = ready_q;

    // ------------------------------------------------------------------
    // Storage array. Clear sequencer has priority; it only runs while
    // ready is low, so it never competes with a real write.
    // ------------------------------------------------------------------
    // NOTE: the array has no reset branch on purpose; resetting a memory
    // turns it into flops. The clear sequencer initialises it instead.
    always_ff @(posedge vsi_clk) begin
        if (clear_we) begin
            mem[clr_cnt] <= INIT_VALUE;
        end else if (wr_fire) begin
            for (int b = 0; b < BYTES; b++) begin
                if (vsi_inputByteEn[b]) begin
                    mem[vsi_inputAddr][8*b +: 8] <= vsi_inputData[8*b +: 8];
                end
            end
        end
    end

    // Read word with write-first bypass: enabled bytes of a same-address
    // write replace the stored bytes. Out-of-range reads return zero.
    // NOTE: rd_word gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[vsi_outputAddr];
            if (wr_fire && vsi_inputAddr == vsi_outputAddr) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (vsi_inputByteEn[b]) begin
                        rd_word[8*b +: 8] = vsi_inputData[8*b +: 8];
                    end
                end
            end
        end
    end

    // First read stage: data only loads on an accepted read, so it holds
    // the last result while valid is low.
    always_ff @(posedge vsi_clk or posedge vsi_reset) begin
        if (vsi_reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= rd_word;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] out_data_q;
            logic              out_valid_q;

            always_ff @(posedge vsi_clk or posedge vsi_reset) begin
                if (vsi_reset) begin
                    out_data_q  <= '0;
                    out_valid_q <= 1'b0;
                end else begin
                    out_valid_q <= rd_valid_q;
                    if (rd_valid_q) begin
                        out_data_q <= rd_data_q;
                    end
                end
            end

            assign vsi_outputData  = out_data_q;
            assign vsi_outputValid = out_valid_q;
        end else begin : g_lat1
            assign vsi_outputData  = rd_data_q;
            assign vsi_outputValid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_vsi_sram_bank_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vsi_sram_bank_ctrl
//   Drives three bank instances from shared inputs:
//     dut_a : defaults (128 words, RD_LAT=1)
//     dut_b : RD_LAT=2
//     dut_c : DEPTH=100, ADDR_W=7, RD_LAT=1
//   Directed vector table plus hand-written clear/burst/reset sequences.
// ----------------------------------------------------------------------------
module tb_vsi_sram_bank_ctrl;

    logic         clk;
    logic         rst;
    logic [127:0] wdata;
    logic [6:0]   waddr;
    logic         wcs;
    logic [15:0]  be;
    logic         rcs;
    logic [6:0]   raddr;

    logic [127:0] d_a, d_b, d_c;
    logic         v_a, v_b, v_c;
    logic         r_a, r_b, r_c;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic         we;
        logic [6:0]   waddr;
        logic [127:0] wdata;
        logic [15:0]  be;
        logic         re;
        logic [6:0]   raddr;
        logic [127:0] exp_full;   // expected from 128-word banks
        logic [127:0] exp_small;  // expected from the 100-word bank
    } vec_t;

    vec_t vecs[14];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vsi_sram_bank_ctrl dut_a (
        .vsi_clk(clk), .vsi_reset(rst),
        .vsi_inputData(wdata), .vsi_inputAddr(waddr),
        .vsi_inputChipSelect(wcs), .vsi_inputByteEn(be),
        .vsi_outputChipSelect(rcs), .vsi_outputAddr(raddr),
        .vsi_outputData(d_a), .vsi_outputValid(v_a), .vsi_ready(r_a)
    );

    vsi_sram_bank_ctrl #(.RD_LAT(2)) dut_b (
        .vsi_clk(clk), .vsi_reset(rst),
        .vsi_inputData(wdata), .vsi_inputAddr(waddr),
        .vsi_inputChipSelect(wcs), .vsi_inputByteEn(be),
        .vsi_outputChipSelect(rcs), .vsi_outputAddr(raddr),
        .vsi_outputData(d_b), .vsi_outputValid(v_b), .vsi_ready(r_b)
    );

    vsi_sram_bank_ctrl #(.DEPTH(100), .ADDR_W(7)) dut_c (
        .vsi_clk(clk), .vsi_reset(rst),
        .vsi_inputData(wdata), .vsi_inputAddr(waddr),
        .vsi_inputChipSelect(wcs), .vsi_inputByteEn(be),
        .vsi_outputChipSelect(rcs), .vsi_outputAddr(raddr),
        .vsi_outputData(d_c), .vsi_outputValid(v_c), .vsi_ready(r_c)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int a);
        logic [7:0] b;
        b = 8'(a) ^ 8'h5A;
        return {16{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for all banks to finish clearing; chip selects are toggled
    // mid-clear on a word already cleared, so a leaked write would persist.
    task automatic wait_clear(input string tag);
        int   c_a = 0, c_b = 0, c_c = 0;
        logic any_valid = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            if (k >= 50 && k < 90) begin
                wcs = 1'b1; waddr = 7'd2; wdata = {128{1'b1}}; be = 16'hFFFF;
                rcs = 1'b1; raddr = 7'd2;
            end else begin
                wcs = 1'b0; rcs = 1'b0;
            end
            tick();
            any_valid = any_valid | v_a | v_b | v_c;
            if (r_a && c_a == 0) c_a = k;
            if (r_b && c_b == 0) c_b = k;
            if (r_c && c_c == 0) c_c = k;
            if (c_a != 0 && c_b != 0 && c_c != 0) break;
        end
        wcs = 1'b0; rcs = 1'b0;
        check({tag, "_ready_cycles_a"}, 128'(c_a), 128'd128);
        check({tag, "_ready_cycles_b"}, 128'(c_b), 128'd128);
        check({tag, "_ready_cycles_c"}, 128'(c_c), 128'd100);
        check({tag, "_no_valid_in_clear"}, 128'(any_valid), 128'd0);
    endtask

    // One vector, then idle cycles; RD_LAT=1 banks answer after the
    // sampling edge, the RD_LAT=2 bank one edge later.
    task automatic apply_vec(input vec_t v, input string tag);
        wcs = v.we; waddr = v.waddr; wdata = v.wdata; be = v.be;
        rcs = v.re; raddr = v.raddr;
        tick();
        wcs = 1'b0; rcs = 1'b0;
        check({tag, "_valid_a"}, 128'(v_a), 128'(v.re));
        check({tag, "_valid_c"}, 128'(v_c), 128'(v.re));
        check({tag, "_valid_b_early"}, 128'(v_b), 128'd0);
        if (v.re) begin
            check({tag, "_data_a"}, d_a, v.exp_full);
            check({tag, "_data_c"}, d_c, v.exp_small);
        end
        tick();
        check({tag, "_valid_b"}, 128'(v_b), 128'(v.re));
        check({tag, "_valid_a_after"}, 128'(v_a), 128'd0);
        if (v.re) begin
            check({tag, "_data_b"}, d_b, v.exp_full);
        end
    endtask

    // Back-to-back reads of every address, one per cycle.
    task automatic burst_read(input logic use_pat, input string tag);
        for (int i = 0; i <= 129; i++) begin
            if (i < 128) begin
                rcs = 1'b1; raddr = 7'(i);
            end else begin
                rcs = 1'b0;
            end
            tick();
            if (i < 128) begin
                check($sformatf("%s_v_a_%0d", tag, i), 128'(v_a), 128'd1);
                check($sformatf("%s_d_a_%0d", tag, i), d_a, use_pat ? pat(i) : 128'd0);
                check($sformatf("%s_v_c_%0d", tag, i), 128'(v_c), 128'd1);
                check($sformatf("%s_d_c_%0d", tag, i), d_c,
                      (use_pat && i < 100) ? pat(i) : 128'd0);
            end else if (i == 128) begin
                check({tag, "_v_a_end"}, 128'(v_a), 128'd0);
            end
            if (i >= 1 && i <= 128) begin
                check($sformatf("%s_v_b_%0d", tag, i - 1), 128'(v_b), 128'd1);
                check($sformatf("%s_d_b_%0d", tag, i - 1), d_b, use_pat ? pat(i - 1) : 128'd0);
            end else if (i == 129) begin
                check({tag, "_v_b_end"}, 128'(v_b), 128'd0);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_a"}, d_a, 128'd0);
        check({tag, "_data_b"}, d_b, 128'd0);
        check({tag, "_data_c"}, d_c, 128'd0);
        check({tag, "_valid_abc"}, {125'd0, v_a, v_b, v_c}, 128'd0);
        check({tag, "_ready_abc"}, {125'd0, r_a, r_b, r_c}, 128'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        //             we    waddr   wdata            be          re    raddr   exp_full                       exp_small
        vecs[0]  = '{1'b1, 7'd5,   {16{8'hA5}},     16'hFFFF, 1'b0, 7'd0,   128'd0,                        128'd0};
        vecs[1]  = '{1'b1, 7'd5,   {16{8'h3C}},     16'h0001, 1'b0, 7'd0,   128'd0,                        128'd0};
        vecs[2]  = '{1'b0, 7'd0,   128'd0,          16'h0000, 1'b1, 7'd5,   {{15{8'hA5}}, 8'h3C},          {{15{8'hA5}}, 8'h3C}};
        vecs[3]  = '{1'b1, 7'd9,   128'h1234,       16'hFFFF, 1'b1, 7'd9,   128'h1234,                     128'h1234};
        vecs[4]  = '{1'b1, 7'd9,   {16{8'hFF}},     16'h0000, 1'b1, 7'd9,   128'h1234,                     128'h1234};
        vecs[5]  = '{1'b1, 7'd20,  {16{8'hFF}},     16'hF000, 1'b1, 7'd20,  {32'hFFFF_FFFF, 96'd0},        {32'hFFFF_FFFF, 96'd0}};
        vecs[6]  = '{1'b1, 7'd30,  {16{8'h77}},     16'hFFFF, 1'b1, 7'd31,  128'd0,                        128'd0};
        vecs[7]  = '{1'b0, 7'd0,   128'd0,          16'h0000, 1'b1, 7'd30,  {16{8'h77}},                   {16{8'h77}}};
        vecs[8]  = '{1'b1, 7'd110, {16{8'hEE}},     16'hFFFF, 1'b0, 7'd0,   128'd0,                        128'd0};
        vecs[9]  = '{1'b0, 7'd0,   128'd0,          16'h0000, 1'b1, 7'd110, {16{8'hEE}},                   128'd0};
        vecs[10] = '{1'b1, 7'd111, {16{8'h11}},     16'hFFFF, 1'b1, 7'd111, {16{8'h11}},                   128'd0};
        vecs[11] = '{1'b0, 7'd0,   128'd0,          16'h0000, 1'b1, 7'd10,  128'd0,                        128'd0};
        vecs[12] = '{1'b1, 7'd40,  {16{8'hC3}},     16'hFFFF, 1'b1, 7'd5,   {{15{8'hA5}}, 8'h3C},          {{15{8'hA5}}, 8'h3C}};
        vecs[13] = '{1'b0, 7'd0,   128'd0,          16'h0000, 1'b1, 7'd20,  {32'hFFFF_FFFF, 96'd0},        {32'hFFFF_FFFF, 96'd0}};

        rst = 1'b1; wcs = 1'b0; rcs = 1'b0; waddr = '0; raddr = '0; wdata = '0; be = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_clear("clear1");

        burst_read(1'b0, "zero");

        for (int i = 0; i < 14; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end

        for (int a = 0; a < 128; a++) begin
            wcs = 1'b1; waddr = 7'(a); wdata = pat(a); be = 16'hFFFF;
            tick();
        end
        wcs = 1'b0;
        burst_read(1'b1, "pat");

        // Reset in the middle of a read burst.
        for (int i = 0; i < 10; i++) begin
            rcs = 1'b1; raddr = 7'(i);
            tick();
        end
        check("burst_valid_before_reset", 128'(v_a), 128'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_burst");
        rcs = 1'b0;
        tick();
        rst = 1'b0;

        // Reset again with the clear counter at 60.
        repeat (60) @(posedge clk);
        #1;
        check("mid_clear_not_ready", 128'(r_a), 128'd0);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_clear");
        tick();
        rst = 1'b0;
        wait_clear("clear2");

        apply_vec('{1'b0, 7'd0, 128'd0, 16'h0, 1'b1, 7'd0,  128'd0, 128'd0}, "post_clear_w0");
        apply_vec('{1'b0, 7'd0, 128'd0, 16'h0, 1'b1, 7'd2,  128'd0, 128'd0}, "post_clear_w2");
        apply_vec('{1'b0, 7'd0, 128'd0, 16'h0, 1'b1, 7'd99, 128'd0, 128'd0}, "post_clear_w99");
        apply_vec('{1'b0, 7'd0, 128'd0, 16'h0, 1'b1, 7'd127, 128'd0, 128'd0}, "post_clear_w127");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
